// File: rtl/nrisc_ula_pkg.sv
// nrisc_ula_pkg
// Shared definitions for the ULA and the multi-cycle sequencer that owns the
// ULA select path: command encodings, flag bit positions, sequencer state
// encoding and the ULA ownership type.
package nrisc_ula_pkg;

   // ULA commands
   localparam logic [3:0] CMD_ADD = 4'b0000;
   localparam logic [3:0] CMD_SUB = 4'b0001;
   localparam logic [3:0] CMD_SHR = 4'b1000;
   localparam logic [3:0] CMD_XOR = 4'b1001;
   localparam logic [3:0] CMD_AND = 4'b1010;
   localparam logic [3:0] CMD_OR  = 4'b1011;
   localparam logic [3:0] CMD_SHL = 4'b1100;

   // Bit positions inside the 3-bit flag vector {minus, zero, carry}
   localparam int FLAG_CARRY = 0;
   localparam int FLAG_ZERO  = 1;
   localparam int FLAG_MINUS = 2;

   // Sequencer state encoding
   localparam int         ST_W    = 3;
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_ADD  = 3'd1;
   localparam logic [2:0] ST_SHL  = 3'd2;
   localparam logic [2:0] ST_SHR  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // Who drives the ULA operand/command inputs
   typedef enum logic {
      OWN_PIPE = 1'b0,
      OWN_SEQ  = 1'b1
   } ula_owner_e;

   // The sequencer holds the ULA (and refuses pipeline requests) in these states
   function automatic logic is_busy_state(input logic [2:0] st);
      return (st == ST_ADD) || (st == ST_SHL) || (st == ST_SHR);
   endfunction

endpackage

// File: rtl/nrisc_ula_mul_seq_if.sv
// nrisc_ula_mul_seq_if
// Groups the pipeline-side ULA request path and the multiply handshake of
// the sequencer.
//   PIPE_A/B/ctrl/req  pipeline ULA request      (master -> slave)
//   PIPE_stall         request refused this cycle (slave -> master)
//   PIPE_OUT/flags     ULA result forwarded       (slave -> master)
//   MUL_start/A/B      multiply start + operands  (master -> slave)
//   MUL_busy/done      sequence status            (slave -> master)
//   MUL_result         registered product         (slave -> master)
interface nrisc_ula_mul_seq_if #(
   parameter int TAM = 16
);
   logic [TAM-1:0] PIPE_A;
   logic [TAM-1:0] PIPE_B;
   logic [3:0]     PIPE_ctrl;
   logic           PIPE_req;
   logic           PIPE_stall;
   logic [TAM-1:0] PIPE_OUT;
   logic [2:0]     PIPE_flags;

   logic           MUL_start;
   logic [TAM-1:0] MUL_A;
   logic [TAM-1:0] MUL_B;
   logic           MUL_busy;
   logic           MUL_done;
   logic [TAM-1:0] MUL_result;

   modport master (
      output PIPE_A, PIPE_B, PIPE_ctrl, PIPE_req,
      input  PIPE_stall, PIPE_OUT, PIPE_flags,
      output MUL_start, MUL_A, MUL_B,
      input  MUL_busy, MUL_done, MUL_result
   );

   modport slave (
      input  PIPE_A, PIPE_B, PIPE_ctrl, PIPE_req,
      output PIPE_stall, PIPE_OUT, PIPE_flags,
      input  MUL_start, MUL_A, MUL_B,
      output MUL_busy, MUL_done, MUL_result
   );
endinterface

// File: rtl/nrisc_ula.sv
// nrisc_ula
// Combinational ULA.
//   A, B   operands (TAM bits)
//   ctrl   command (see nrisc_ula_pkg CMD_*)
//   OUT    result, low TAM bits
//   flags  {minus, zero, carry}; carry is the bit above OUT (add carry,
//          subtract borrow, last bit shifted out by SHL)
module nrisc_ula
   import nrisc_ula_pkg::*;
#(
   parameter int TAM = 16
) (
   input  logic [TAM-1:0] A,
   input  logic [TAM-1:0] B,
   input  logic [3:0]     ctrl,
   output logic [TAM-1:0] OUT,
   output logic [2:0]     flags
);

   logic [TAM:0] wide;

   always_comb begin
      wide = '0;
      case (ctrl)
         CMD_ADD: wide = {1'b0, A} + {1'b0, B};
         CMD_SUB: wide = {1'b0, A} - {1'b0, B};
         CMD_SHR: wide = {1'b0, A >> B};
         CMD_SHL: wide = {1'b0, A} << B;
         CMD_AND: wide = {1'b0, A & B};
         CMD_OR:  wide = {1'b0, A | B};
         CMD_XOR: wide = {1'b0, A ^ B};
         default: wide = '0;
      endcase
   end

   assign OUT               = wide[TAM-1:0];
   assign flags[FLAG_CARRY] = wide[TAM];
   assign flags[FLAG_ZERO]  = (wide[TAM-1:0] == '0);
   assign flags[FLAG_MINUS] = wide[TAM-1];

endmodule

// File: rtl/nrisc_ula_port_mux.sv
// nrisc_ula_port_mux
// Owner mux in front of the ULA: selects pipeline or sequencer drive of the
// ULA operand and command inputs.
//   owner            OWN_PIPE / OWN_SEQ
//   pipe_a/b/ctrl    pipeline request
//   seq_a/b/ctrl     sequencer drive
//   ula_a/b/ctrl     to the ULA
module nrisc_ula_port_mux
   import nrisc_ula_pkg::*;
#(
   parameter int TAM = 16
) (
   input  ula_owner_e     owner,
   input  logic [TAM-1:0] pipe_a,
   input  logic [TAM-1:0] pipe_b,
   input  logic [3:0]     pipe_ctrl,
   input  logic [TAM-1:0] seq_a,
   input  logic [TAM-1:0] seq_b,
   input  logic [3:0]     seq_ctrl,
   output logic [TAM-1:0] ula_a,
   output logic [TAM-1:0] ula_b,
   output logic [3:0]     ula_ctrl
);

   always_comb begin
      if (owner == OWN_SEQ) begin
         ula_a    = seq_a;
         ula_b    = seq_b;
         ula_ctrl = seq_ctrl;
      end else begin
         ula_a    = pipe_a;
         ula_b    = pipe_b;
         ula_ctrl = pipe_ctrl;
      end
   end

endmodule

// File: rtl/nrisc_ula_mul_seq.sv
// nrisc_ula_mul_seq
// Multi-cycle controller that owns the ULA select path. Idle: pipeline ULA
// requests pass straight through. On MUL_start it borrows the ULA and runs
// an unsigned shift-add multiply (low TAM bits of A*B) using only ADD, SHL
// and SHR, then hands the ULA back.
//   clk, rst_n          clock, async active-low reset
//   bus (slave)         pipeline request path + multiply handshake
//   ULA_A/B/ctrl        to the ULA
//   ULA_OUT, ULA_flags  from the ULA ({minus, zero, carry})
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | ULA owned by pipeline; MUL_start loads operands
// ADD     | acc += mcand when mplr[0]=1 (ULA driven with ADD 0+0 otherwise)
// SHL     | mcand <<= 1
// SHR     | mplr >>= 1, cnt++; leave when mplr hits zero or last bit done
// DONE    | MUL_done pulse, ULA back to pipeline
module nrisc_ula_mul_seq
   import nrisc_ula_pkg::*;
#(
   parameter int TAM = 16,
   parameter int CW  = $clog2(TAM)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   nrisc_ula_mul_seq_if.slave    bus,
   output logic [TAM-1:0]        ULA_A,
   output logic [TAM-1:0]        ULA_B,
   output logic [3:0]            ULA_ctrl,
   input  logic [TAM-1:0]        ULA_OUT,
   input  logic [2:0]            ULA_flags
);

   logic [ST_W-1:0] state_q, state_d;
   logic [TAM-1:0]  acc_q, acc_d;
   logic [TAM-1:0]  mcand_q, mcand_d;
   logic [TAM-1:0]  mplr_q, mplr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TAM-1:0]  result_q, result_d;

   ula_owner_e      owner;
   logic [TAM-1:0]  seq_a;
   logic [TAM-1:0]  seq_b;
   logic [3:0]      seq_ctrl;
   logic            mul_done;
   logic            mul_busy;

   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplr_d   = mplr_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      owner    = OWN_PIPE;
      seq_a    = '0;
      seq_b    = '0;
      seq_ctrl = CMD_ADD;
      mul_done = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (bus.MUL_start) begin
               acc_d   = '0;
               mcand_d = bus.MUL_A;
               mplr_d  = bus.MUL_B;
               cnt_d   = '0;
               if (bus.MUL_B == '0) begin
                  // Product is trivially zero; publish it on entry to DONE
                  result_d = '0;
                  state_d  = ST_DONE;
               end else begin
                  state_d = ST_ADD;
               end
            end
         end

         ST_ADD: begin
            owner = OWN_SEQ;
            if (mplr_q[0]) begin
               seq_a = acc_q;
               seq_b = mcand_q;
               acc_d = ULA_OUT;
            end
            state_d = ST_SHL;
         end

         ST_SHL: begin
            owner    = OWN_SEQ;
            seq_a    = mcand_q;
            seq_b    = TAM'(1);
            seq_ctrl = CMD_SHL;
            mcand_d  = ULA_OUT;
            state_d  = ST_SHR;
         end

         ST_SHR: begin
            owner    = OWN_SEQ;
            seq_a    = mplr_q;
            seq_b    = TAM'(1);
            seq_ctrl = CMD_SHR;
            mplr_d   = ULA_OUT;
            cnt_d    = cnt_q + CW'(1);
            if (ULA_flags[FLAG_ZERO] || (cnt_q == CW'(TAM - 1))) begin
               // acc is final here (SHR never touches it); loading the result
               // now makes MUL_result valid in the same cycle as MUL_done
               result_d = acc_q;
               state_d  = ST_DONE;
            end else begin
               state_d = ST_ADD;
            end
         end

         ST_DONE: begin
            mul_done = 1'b1;
            state_d  = ST_IDLE;
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         mcand_q  <= '0;
         mplr_q   <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplr_q   <= mplr_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   assign mul_busy = is_busy_state(state_q);

   nrisc_ula_port_mux #(
      .TAM (TAM)
   ) u_port_mux (
      .owner     (owner),
      .pipe_a    (bus.PIPE_A),
      .pipe_b    (bus.PIPE_B),
      .pipe_ctrl (bus.PIPE_ctrl),
      .seq_a     (seq_a),
      .seq_b     (seq_b),
      .seq_ctrl  (seq_ctrl),
      .ula_a     (ULA_A),
      .ula_b     (ULA_B),
      .ula_ctrl  (ULA_ctrl)
   );

   assign bus.PIPE_stall = bus.PIPE_req & mul_busy;
   assign bus.PIPE_OUT   = ULA_OUT;
   assign bus.PIPE_flags = ULA_flags;
   assign bus.MUL_busy   = mul_busy;
   assign bus.MUL_done   = mul_done;
   assign bus.MUL_result = result_q;

endmodule

// File: doc/nrisc_ula_mul_seq.md
Name: nrisc_ula_mul_seq

Overview:
- Multi-cycle controller that owns the ULA select path.
- When idle, it passes pipeline ULA requests straight through to the ULA.
- When a multiply is started, it takes the ULA and runs an unsigned shift-add multiply (low TAM bits of A*B) using only ULA ADD, SHL and SHR operations, then returns the ULA to the pipeline.
- Sits between decode/execute and the ULA instance.

Parameters:
TAM, 16, datapath width; must match the ULA's TAM (4..32).
CW, $clog2(TAM), width of the iteration counter.

Ports:
clk  in  1  clock.
rst_n  in  1  asynchronous reset, active-low.
PIPE_A  in  TAM  pipeline ULA operand A.
PIPE_B  in  TAM  pipeline ULA operand B.
PIPE_ctrl  in  4  pipeline ULA command.
PIPE_req  in  1  pipeline wants the ULA this cycle.
PIPE_stall  out  1  pipeline request refused this cycle.
PIPE_OUT  out  TAM  ULA_OUT forwarded to the pipeline.
PIPE_flags  out  3  ULA_flags forwarded to the pipeline.
MUL_start  in  1  start pulse; sampled only in IDLE.
MUL_A  in  TAM  multiplicand.
MUL_B  in  TAM  multiplier.
MUL_busy  out  1  sequence in progress.
MUL_done  out  1  one-cycle pulse; MUL_result valid.
MUL_result  out  TAM  registered product, low TAM bits.
ULA_A  out  TAM  to ULA.
ULA_B  out  TAM  to ULA.
ULA_ctrl  out  4  to ULA.
ULA_OUT  in  TAM  from ULA.
ULA_flags  in  3  from ULA, {minus, zero, carry}.

Behaviour:
- Reset, asynchronous, rst_n=0:
  - state IDLE; acc, mcand, mplr, counter and MUL_result all 0.
  - MUL_busy=0, MUL_done=0.
  - A reset mid-sequence aborts the sequence with no done pulse.
- States: IDLE, ADD, SHL, SHR, DONE.
- IDLE:
  - ULA_A/B/ctrl = PIPE_A/B/ctrl (combinational mux); PIPE_stall=0.
  - On MUL_start: acc<=0, mcand<=MUL_A, mplr<=MUL_B, cnt<=0.
  - Next state is DONE if MUL_B==0, else ADD.
  - A pipeline op presented in the same cycle as MUL_start is still passed through.
- ADD:
  - If mplr[0]=1: ULA_A=acc, ULA_B=mcand, ULA_ctrl=CMD_ADD (0000); acc<=ULA_OUT.
  - If mplr[0]=0: acc is held and the ULA is driven with CMD_ADD and zero operands.
  - Always 1 cycle; next state SHL.
- SHL: ULA_A=mcand, ULA_B=1, ULA_ctrl=CMD_SHL (1100); mcand<=ULA_OUT. Next state SHR.
- SHR:
  - ULA_A=mplr, ULA_B=1, ULA_ctrl=CMD_SHR (1000); mplr<=ULA_OUT; cnt<=cnt+1.
  - Next state is DONE if ULA_flags[1] (zero) = 1 or cnt==TAM-1; otherwise ADD.
- DONE:
  - MUL_result<=acc; MUL_done=1 for this cycle only.
  - ULA mux returns to the pipeline path as in IDLE; PIPE_stall=0.
  - Next state IDLE.
- MUL_busy=1 in ADD, SHL and SHR.
- PIPE_stall = PIPE_req & MUL_busy. A stalled pipeline request is not executed; the pipeline must hold it.
- MUL_start while busy or in DONE is ignored (no queueing).
- Arithmetic:
  - Unsigned; bits above TAM-1 are discarded (mod 2^TAM).
  - ULA carry and minus flags are ignored by the sequencer; only the zero flag is used.
- Latency from the start edge to the MUL_done cycle is 3*k+1 cycles, where k = index of the highest set bit of MUL_B plus 1.
  - Maximum is 3*TAM+1.
  - MUL_B=0 gives 1 cycle.
- MUL_result holds its value until the next DONE.
- PIPE_OUT and PIPE_flags are always wired straight from ULA_OUT and ULA_flags. They are meaningful only when not busy.

Decomposition:
- Shared package nrisc_ula_pkg holds:
  - ULA command constants CMD_ADD=4'b0000, CMD_SUB=4'b0001, CMD_SHR=4'b1000, CMD_SHL=4'b1100.
  - Flag index constants FLAG_CARRY=0, FLAG_ZERO=1, FLAG_MINUS=2.
  - State encoding.
- One natural sub-module: nrisc_ula_port_mux. It is the combinational owner mux selecting pipeline vs sequencer drive of ULA_A/B/ctrl.
- The FSM and datapath registers stay in the top module.
- The bench instantiates the real ULA with TAM=16.

Test Plan:
- Reset mid-op: MUL_start with A=7, B=0xFFFF; drop rst_n after 5 cycles -> MUL_busy=0 and MUL_done=0 immediately; the following MUL_start with A=2, B=3 returns 6.
- MUL_A=3, MUL_B=5 -> MUL_busy high for cycles 1-9; MUL_done pulses in cycle 10 with MUL_result=0x000F; state IDLE in cycle 11.
- MUL_A=0x1234, MUL_B=0 -> MUL_done in cycle 1, MUL_result=0x0000, the ULA never driven by the sequencer.
- MUL_A=0xFFFF, MUL_B=0xFFFF -> MUL_done at cycle 49, MUL_result=0x0001.
- MUL_A=0x8000, MUL_B=2 -> wrap-around discarded, MUL_result=0x0000 at cycle 7.
- PIPE_req held with PIPE_ctrl=0xA (AND), A=0xF0F0, B=0x0FF0 during a multiply -> PIPE_stall=1 every busy cycle; in the DONE cycle PIPE_stall=0 and PIPE_OUT=0x00F0; a MUL_start issued while busy produces no extra MUL_done.
